// File: rtl/reqrsp_pkg.sv
// Request/response encodings shared by the TCDM interconnect and its endpoints.
// Only the AMO opcode enumeration is needed by the bank adapter.
package reqrsp_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

endpackage

// File: rtl/spatz_tcdm_bank_adapter_if.sv
// Memory-side TCDM port bundle: request channel plus the fixed-latency response data.
// The interconnect drives the master side; the bank adapter sits on the slave side.
interface spatz_tcdm_bank_adapter_if
    import reqrsp_pkg::*;
#(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned UserWidth = 1
) ();

    localparam int unsigned StrbWidth = DataWidth / 8;

    logic                 q_valid;
    logic                 q_ready;
    logic [AddrWidth-1:0] q_addr;
    logic                 q_write;
    amo_op_e              q_amo;
    logic [DataWidth-1:0] q_data;
    logic [StrbWidth-1:0] q_strb;
    logic [UserWidth-1:0] q_user;
    logic [DataWidth-1:0] p_data;

    modport master (
        output q_valid, q_addr, q_write, q_amo, q_data, q_strb, q_user,
        input  q_ready, p_data
    );

    modport slave (
        input  q_valid, q_addr, q_write, q_amo, q_data, q_strb, q_user,
        output q_ready, p_data
    );

endinterface

// File: rtl/spatz_amo_alu.sv
// Combinational RISC-V AMO datapath: new memory value from the old value and the operand.
// Shared between the TCDM bank adapter and the core-side AMO path.
module spatz_amo_alu
    import reqrsp_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  amo_op_e              op_i,
    input  logic [DataWidth-1:0] old_i,
    input  logic [DataWidth-1:0] operand_i,
    output logic [DataWidth-1:0] result_c
);

    logic lt_signed_c;
    logic lt_unsigned_c;

    assign lt_signed_c   = $signed(old_i) < $signed(operand_i);
    assign lt_unsigned_c = old_i < operand_i;

    always_comb begin
        result_c = operand_i;
        case (op_i)
            AMOSwap: result_c = operand_i;
            AMOAdd:  result_c = old_i + operand_i;
            AMOAnd:  result_c = old_i & operand_i;
            AMOOr:   result_c = old_i | operand_i;
            AMOXor:  result_c = old_i ^ operand_i;
            AMOMax:  result_c = lt_signed_c   ? operand_i : old_i;
            AMOMaxu: result_c = lt_unsigned_c ? operand_i : old_i;
            AMOMin:  result_c = lt_signed_c   ? old_i : operand_i;
            AMOMinu: result_c = lt_unsigned_c ? old_i : operand_i;
            default: result_c = operand_i;
        endcase
    end

endmodule

// File: rtl/spatz_tcdm_bank_adapter.sv
// Adapter between one TCDM interconnect output and a single-port SRAM bank.
// Returns read data one cycle after acceptance and executes AMOs/LR/SC as local RMW.
module spatz_tcdm_bank_adapter
    import reqrsp_pkg::*;
#(
    parameter  int unsigned AddrWidth = 10,
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned UserWidth = 1,
    localparam int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 q_valid_i,
    output logic                 q_ready_o,
    input  logic [AddrWidth-1:0] q_addr_i,
    input  logic                 q_write_i,
    input  amo_op_e              q_amo_i,
    input  logic [DataWidth-1:0] q_data_i,
    input  logic [StrbWidth-1:0] q_strb_i,
    input  logic [UserWidth-1:0] q_user_i,
    output logic [DataWidth-1:0] p_data_o,

    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [StrbWidth-1:0] sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    typedef enum logic {
        IDLE   = 1'b0,
        AMO_WB = 1'b1
    } state_e;

    function automatic logic is_rmw(input amo_op_e op);
        return op inside {AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
                          AMOMax, AMOMaxu, AMOMin, AMOMinu};
    endfunction

    state_e               state_q,      state_d;
    amo_op_e              op_q,         op_d;
    logic [DataWidth-1:0] operand_q,    operand_d;
    logic [AddrWidth-1:0] addr_q,       addr_d;
    logic                 resv_valid_q, resv_valid_d;
    logic [AddrWidth-1:0] resv_addr_q,  resv_addr_d;
    logic [UserWidth-1:0] resv_user_q,  resv_user_d;
    logic                 sc_fail_q,    sc_fail_d;
    logic                 resp_sc_q,    resp_sc_d;

    logic                 ready_c;
    logic                 req_c;
    logic                 we_c;
    logic [AddrWidth-1:0] addr_c;
    logic [DataWidth-1:0] wdata_c;
    logic [StrbWidth-1:0] be_c;
    logic [DataWidth-1:0] amo_result_c;
    logic                 resv_hit_q_c;
    logic                 resv_hit_wb_c;
    logic                 sc_ok_c;

    assign resv_hit_q_c  = resv_valid_q && (resv_addr_q == q_addr_i);
    assign resv_hit_wb_c = resv_valid_q && (resv_addr_q == addr_q);
    assign sc_ok_c       = resv_hit_q_c && (resv_user_q == q_user_i);

    spatz_amo_alu #(
        .DataWidth (DataWidth)
    ) i_amo_alu (
        .op_i      (op_q),
        .old_i     (sram_rdata_i),
        .operand_i (operand_q),
        .result_c  (amo_result_c)
    );

    // Next-state, SRAM drive and reservation tracking
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        operand_d    = operand_q;
        addr_d       = addr_q;
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        resv_user_d  = resv_user_q;
        sc_fail_d    = sc_fail_q;
        resp_sc_d    = 1'b0;

        ready_c      = 1'b0;
        req_c        = 1'b0;
        we_c         = 1'b0;
        addr_c       = q_addr_i;
        wdata_c      = q_data_i;
        be_c         = q_strb_i;

        unique case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (q_valid_i) begin
                    case (q_amo_i)
                        AMOLR: begin
                            req_c        = 1'b1;
                            resv_valid_d = 1'b1;
                            resv_addr_d  = q_addr_i;
                            resv_user_d  = q_user_i;
                        end
                        AMOSC: begin
                            resp_sc_d    = 1'b1;
                            resv_valid_d = 1'b0;
                            sc_fail_d    = !sc_ok_c;
                            if (sc_ok_c) begin
                                req_c = 1'b1;
                                we_c  = 1'b1;
                                be_c  = '1;
                            end
                        end
                        default: begin
                            req_c = 1'b1;
                            if (is_rmw(q_amo_i)) begin
                                be_c      = '1;
                                op_d      = q_amo_i;
                                operand_d = q_data_i;
                                addr_d    = q_addr_i;
                                state_d   = AMO_WB;
                            end else begin
                                we_c = q_write_i;
                                if (q_write_i && resv_hit_q_c) begin
                                    resv_valid_d = 1'b0;
                                end
                            end
                        end
                    endcase
                end
            end
            AMO_WB: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = addr_q;
                wdata_c = amo_result_c;
                be_c    = '1;
                if (resv_hit_wb_c) begin
                    resv_valid_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            op_q         <= AMONone;
            operand_q    <= '0;
            addr_q       <= '0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            resv_user_q  <= '0;
            sc_fail_q    <= 1'b0;
            resp_sc_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            operand_q    <= operand_d;
            addr_q       <= addr_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            resv_user_q  <= resv_user_d;
            sc_fail_q    <= sc_fail_d;
            resp_sc_q    <= resp_sc_d;
        end
    end

    // Reset masks the port and the SRAM enables immediately, aborting any writeback
    assign q_ready_o    = ready_c && !rst_i;
    assign sram_req_o   = req_c && !rst_i;
    assign sram_we_o    = we_c && !rst_i;
    assign sram_addr_o  = addr_c;
    assign sram_wdata_o = wdata_c;
    assign sram_be_o    = be_c;
    assign p_data_o     = rst_i     ? '0 :
                          resp_sc_q ? DataWidth'(sc_fail_q) : sram_rdata_i;

endmodule

// File: tb/tb_spatz_tcdm_bank_adapter.sv
// Scoreboard bench for spatz_tcdm_bank_adapter: directed scenarios plus random traffic
// checked against a word-level memory/reservation reference model.
module tb_spatz_tcdm_bank_adapter;
    import reqrsp_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned UW = 1;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned MEM_WORDS = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spatz_tcdm_bank_adapter_if #(.AddrWidth(AW), .DataWidth(DW), .UserWidth(UW)) bus ();

    logic          sram_req, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic [SW-1:0] sram_be;

    spatz_tcdm_bank_adapter #(.AddrWidth(AW), .DataWidth(DW), .UserWidth(UW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .q_valid_i    (bus.q_valid),
        .q_ready_o    (bus.q_ready),
        .q_addr_i     (bus.q_addr),
        .q_write_i    (bus.q_write),
        .q_amo_i      (bus.q_amo),
        .q_data_i     (bus.q_data),
        .q_strb_i     (bus.q_strb),
        .q_user_i     (bus.q_user),
        .p_data_o     (bus.p_data),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Single-port SRAM behaviour: read data appears one cycle after a read
    logic [DW-1:0] mem [MEM_WORDS];
    bit            mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < int'(SW); b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [MEM_WORDS];
    bit            r_valid;
    logic [AW-1:0] r_addr;
    logic [UW-1:0] r_user;

    typedef struct {
        bit            chk;
        logic [DW-1:0] data;
        string         name;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] amo_ref(input amo_op_e op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        int          sa = int'(a);
        int          sb = int'(b);
        int unsigned ua = a;
        int unsigned ub = b;
        case (op)
            AMOSwap: return b;
            AMOAdd:  return DW'(longint'(ua) + longint'(ub));
            AMOAnd:  return a & b;
            AMOOr:   return a | b;
            AMOXor:  return a ^ b;
            AMOMax:  return (sa >= sb) ? a : b;
            AMOMaxu: return (ua >= ub) ? a : b;
            AMOMin:  return (sa <= sb) ? a : b;
            AMOMinu: return (ua <= ub) ? a : b;
            default: return b;
        endcase
    endfunction

    // Architectural effect of one accepted request, and its expected response
    task automatic model(input amo_op_e op, input logic [AW-1:0] a, input logic wr,
                         input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic [UW-1:0] u, output exp_t e);
        bit ok;
        e.chk = 1'b1;
        case (op)
            AMONone: begin
                if (wr) begin
                    for (int b = 0; b < int'(SW); b++)
                        if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                    if (r_valid && r_addr == a) r_valid = 1'b0;
                    e.chk = 1'b0; e.data = '0; e.name = "store";
                end else begin
                    e.data = ref_mem[a]; e.name = "load";
                end
            end
            AMOLR: begin
                e.data = ref_mem[a]; e.name = "lr";
                r_valid = 1'b1; r_addr = a; r_user = u;
            end
            AMOSC: begin
                ok = r_valid && r_addr == a && r_user == u;
                r_valid = 1'b0;
                if (ok) ref_mem[a] = d;
                e.data = ok ? '0 : DW'(1); e.name = "sc";
            end
            default: begin
                e.data = ref_mem[a]; e.name = "amo_old";
                ref_mem[a] = amo_ref(op, ref_mem[a], d);
                if (r_valid && r_addr == a) r_valid = 1'b0;
            end
        endcase
    endtask

    // Present a request and hold it until accepted
    task automatic issue(input amo_op_e op, input logic [AW-1:0] a, input logic wr,
                         input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [UW-1:0] u);
        exp_t e;
        bit   acc = 1'b0;
        @(negedge clk);
        bus.q_valid = 1'b1; bus.q_amo = op; bus.q_addr = a; bus.q_write = wr;
        bus.q_data = d; bus.q_strb = s; bus.q_user = u;
        for (int w = 0; w < 8; w++) begin
            #1;
            if (bus.q_ready) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        if (!acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout: request not accepted within 8 cycles at %0t", $time);
        end else begin
            model(op, a, wr, d, s, u, e);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.q_valid = 1'b0;
        bus.q_addr = AW'($urandom); bus.q_data = $urandom; bus.q_write = 1'b1;
        bus.q_amo = AMOSC; bus.q_strb = '1; bus.q_user = UW'($urandom);
    endtask

    task automatic idle_check_ready(input string name, input logic exp);
        @(negedge clk);
        bus.q_valid = 1'b0;
        #1 check(name, 64'(bus.q_ready), 64'(exp));
    endtask

    // Monitor: every handshake owes a response sampled one cycle later
    initial begin
        bit   pending = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (pending) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL scoreboard: unexpected handshake, p_data 0x%0h", bus.p_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk) check(e.name, 64'(bus.p_data), 64'(e.data));
                end
            end
            #2 pending = bus.q_valid && bus.q_ready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] pick_data();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [AW-1:0] lr_a = '0;
        logic [UW-1:0] lr_u = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_val(i);
        r_valid = 1'b0; r_addr = '0; r_user = '0;
        bus.q_valid = 1'b1; bus.q_addr = '0; bus.q_write = 1'b0; bus.q_amo = AMONone;
        bus.q_data = '0; bus.q_strb = '0; bus.q_user = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_q_ready", 64'(bus.q_ready), 64'd0);
        check("rst_sram_req", 64'(sram_req), 64'd0);
        check("rst_sram_we", 64'(sram_we), 64'd0);
        check("rst_p_data", 64'(bus.p_data), 64'd0);
        bus.q_valid = 1'b0;
        #2 rst = 1'b0;

        // Store then load; ready stays high
        issue(AMONone, 10'd5, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0);
        issue(AMONone, 10'd5, 1'b0, 32'h0, 4'hF, 1'b0);
        idle_check_ready("ready_after_load", 1'b1);

        // AMOAdd: one stall cycle, old value returned, new value visible
        issue(AMONone, 10'd3, 1'b1, 32'd7, 4'hF, 1'b0);
        issue(AMOAdd, 10'd3, 1'b0, 32'd5, 4'hF, 1'b0);
        idle_check_ready("amo_ready_low", 1'b0);
        idle_check_ready("amo_ready_back", 1'b1);
        issue(AMONone, 10'd3, 1'b0, 32'h0, 4'hF, 1'b0);
        // Back-to-back AMOs to one address, second held during writeback
        issue(AMOAdd, 10'd3, 1'b0, 32'd1, 4'hF, 1'b0);
        issue(AMOAdd, 10'd3, 1'b0, 32'd2, 4'hF, 1'b0);
        issue(AMONone, 10'd3, 1'b0, 32'h0, 4'hF, 1'b0);

        // Signed vs unsigned max
        issue(AMONone, 10'd2, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0);
        issue(AMOMax, 10'd2, 1'b0, 32'd1, 4'hF, 1'b0);
        issue(AMONone, 10'd2, 1'b0, 32'h0, 4'hF, 1'b0);
        issue(AMONone, 10'd2, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0);
        issue(AMOMaxu, 10'd2, 1'b0, 32'd1, 4'hF, 1'b0);
        issue(AMONone, 10'd2, 1'b0, 32'h0, 4'hF, 1'b0);

        // LR/SC success then repeated SC failure
        issue(AMOLR, 10'd9, 1'b0, 32'h0, 4'hF, 1'b0);
        issue(AMOSC, 10'd9, 1'b1, 32'h1234_5678, 4'hF, 1'b0);
        issue(AMOSC, 10'd9, 1'b1, 32'hAAAA_5555, 4'hF, 1'b0);
        issue(AMONone, 10'd9, 1'b0, 32'h0, 4'hF, 1'b0);

        // Foreign store kills the reservation
        issue(AMOLR, 10'd9, 1'b0, 32'h0, 4'hF, 1'b0);
        issue(AMONone, 10'd9, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1);
        issue(AMOSC, 10'd9, 1'b1, 32'h0BAD_0BAD, 4'hF, 1'b0);
        issue(AMONone, 10'd9, 1'b0, 32'h0, 4'hF, 1'b0);

        // Reset in the middle of an AMO writeback
        issue(AMOLR, 10'd9, 1'b0, 32'h0, 4'hF, 1'b0);
        issue(AMOAdd, 10'd20, 1'b0, 32'd3, 4'hF, 1'b0);
        @(negedge clk);
        bus.q_valid = 1'b1; bus.q_amo = AMONone; bus.q_write = 1'b0;
        #3 rst = 1'b1;
        r_valid = 1'b0;
        #1;
        check("amo_wb_rst_q_ready", 64'(bus.q_ready), 64'd0);
        check("amo_wb_rst_sram_req", 64'(sram_req), 64'd0);
        @(negedge clk);
        #1;
        check("rst_hold_q_ready", 64'(bus.q_ready), 64'd0);
        check("rst_hold_sram_req", 64'(sram_req), 64'd0);
        bus.q_valid = 1'b0;
        #2 rst = 1'b0;
        idle_check_ready("post_rst_ready", 1'b1);
        issue(AMONone, 10'd20, 1'b1, 32'h1111_2222, 4'hF, 1'b0);
        issue(AMOSC, 10'd9, 1'b1, 32'h9999_9999, 4'hF, 1'b0);
        issue(AMONone, 10'd9, 1'b0, 32'h0, 4'hF, 1'b0);
        issue(AMONone, 10'd20, 1'b0, 32'h0, 4'hF, 1'b0);

        // Random traffic on a small address window
        for (int n = 0; n < 600; n++) begin
            int            r = $urandom_range(0, 15);
            logic [AW-1:0] a = AW'($urandom_range(0, 15));
            logic [UW-1:0] u = UW'($urandom_range(0, 1));
            amo_op_e       op;
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
                continue;
            end
            op = (r > 11) ? AMONone : amo_op_e'(4'(r));
            if (op == AMOSC && $urandom_range(0, 9) < 7) begin
                a = lr_a; u = lr_u;
            end
            if (op == AMOLR) begin
                lr_a = a; lr_u = u;
            end
            issue(op, a, 1'($urandom), pick_data(), SW'($urandom), u);
        end

        repeat (4) idle_cycle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
